// File: rtl/stats_pkg.sv
// Shared definitions for the statistics blocks.
//   - Scan FSM state encoding (READ/WRITE).
//   - acc_width(): local accumulator width for a given increment width and channel count.
//   - sat_add(): add two values at a given width; optionally clamp to all-ones on overflow.
//     Returns {overflow, result}.
package stats_pkg;

  // Scan FSM encoding.
  localparam logic [0:0] StRead  = 1'b0;
  localparam logic [0:0] StWrite = 1'b1;

  // Widest operand sat_add() handles.
  localparam int unsigned SatMaxW = 64;

  // An accumulator is visited every 2*count cycles, so it must hold 2*count maximal increments.
  function automatic int unsigned acc_width(input int unsigned inc_width,
                                            input int unsigned count);
    return inc_width + $clog2(count) + 1;
  endfunction

  // Adds a and b. The result is width bits wide. Overflow means any carry beyond width.
  // With saturate set, an overflowing result becomes all-ones. Otherwise it wraps.
  function automatic logic [SatMaxW:0] sat_add(input logic [SatMaxW-1:0] a,
                                               input logic [SatMaxW-1:0] b,
                                               input int unsigned        width,
                                               input bit                 saturate);
    logic [SatMaxW:0]   full;
    logic [SatMaxW:0]   mask;
    logic [SatMaxW-1:0] res;
    logic               ovf;
    full = {1'b0, a} + {1'b0, b};
    mask = ((SatMaxW + 1)'(1) << width) - (SatMaxW + 1)'(1);
    ovf  = |(full & ~mask);
    res  = (ovf && saturate) ? mask[SatMaxW-1:0] : (full[SatMaxW-1:0] & mask[SatMaxW-1:0]);
    return {ovf, res};
  endfunction

endpackage

// File: rtl/stats_acc.sv
// Single-channel increment accumulator.
//   clk, rst_n : clock, synchronous active-low reset
//   inc        : increment value
//   valid      : increment qualifier
//   enable     : channel enable; when low, valid is ignored
//   clear      : restart the accumulator. It loads the same-cycle increment, so nothing is lost.
//   acc        : current accumulated value
module stats_acc import stats_pkg::*; #(
  parameter int unsigned INC_WIDTH = 8,
  parameter int unsigned ACC_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INC_WIDTH-1:0] inc,
  input  logic                 valid,
  input  logic                 enable,
  input  logic                 clear,
  output logic [ACC_WIDTH-1:0] acc
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] inc_ext;

  always_comb begin
    inc_ext = (valid && enable) ? ACC_WIDTH'(inc) : '0;
    acc_d   = clear ? inc_ext : acc_q + inc_ext;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/stats_collect_multi.sv
// Multi-channel statistics collector.
// Per-channel accumulators are folded into a per-channel RAM total by a READ/WRITE scan.
// Non-zero totals are emitted as AXI-stream increment records (tdata = value, tid = counter ID).
//   clk, rst_n         : clock, synchronous active-low reset
//   stat_inc           : per-channel increments, channel n at [n*INC_WIDTH +: INC_WIDTH]
//   stat_valid         : per-channel increment qualifiers
//   channel_enable     : per-channel enable; a disabled channel ignores stat_valid
//   m_axis_stat_tdata  : record increment value
//   m_axis_stat_tid    : record counter ID (channel + STAT_ID_BASE)
//   m_axis_stat_tvalid : record valid
//   m_axis_stat_tready : downstream accept
//   update             : pulse that marks every channel pending
//   sat_flag           : sticky per-channel flag; the total clamped since the last emit
module stats_collect_multi import stats_pkg::*; #(
  parameter int unsigned COUNT          = 8,
  parameter int unsigned INC_WIDTH      = 8,
  parameter int unsigned STAT_INC_WIDTH = 16,
  parameter int unsigned STAT_ID_WIDTH  = $clog2(COUNT) + 1,
  parameter int unsigned STAT_ID_BASE   = 0,
  parameter int unsigned UPDATE_PERIOD  = 1024,
  parameter bit          SATURATE       = 1'b1,
  parameter bit          EARLY_FLUSH    = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [INC_WIDTH*COUNT-1:0]   stat_inc,
  input  logic [COUNT-1:0]             stat_valid,
  input  logic [COUNT-1:0]             channel_enable,
  output logic [STAT_INC_WIDTH-1:0]    m_axis_stat_tdata,
  output logic [STAT_ID_WIDTH-1:0]     m_axis_stat_tid,
  output logic                         m_axis_stat_tvalid,
  input  logic                         m_axis_stat_tready,
  input  logic                         update,
  output logic [COUNT-1:0]             sat_flag
);

  localparam int unsigned AccWidth = acc_width(INC_WIDTH, COUNT);
  localparam int unsigned ChWidth  = $clog2(COUNT);

  logic [0:0]                state_q, state_d;
  logic [ChWidth-1:0]        ch_q, ch_d;
  logic [COUNT-1:0]          zero_q, zero_d;
  logic [COUNT-1:0]          pending_q, pending_d;
  logic [COUNT-1:0]          sat_q, sat_d;
  logic                      tvalid_q, tvalid_d;
  logic [STAT_INC_WIDTH-1:0] tdata_q, tdata_d;
  logic [STAT_ID_WIDTH-1:0]  tid_q, tid_d;

  logic [STAT_INC_WIDTH-1:0] mem [COUNT];
  logic [STAT_INC_WIDTH-1:0] mem_rd_q;
  logic                      mem_we;
  logic [STAT_INC_WIDTH-1:0] mem_wdata;

  logic [AccWidth-1:0]       acc [COUNT];
  logic [COUNT-1:0]          acc_clear;

  logic                      timer_hit;
  logic                      set_all;

  logic [SatMaxW:0]          add_res;
  logic [STAT_INC_WIDTH-1:0] base_val;
  logic [STAT_INC_WIDTH-1:0] sum;
  logic                      carry;
  logic                      unused_add_bits;

  // Channel accumulators. Each is cleared in its own WRITE cycle.
  for (genvar i = 0; i < COUNT; i++) begin : g_acc
    assign acc_clear[i] = (state_q == StWrite) && (ch_q == ChWidth'(i));

    stats_acc #(
      .INC_WIDTH (INC_WIDTH),
      .ACC_WIDTH (AccWidth)
    ) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (stat_inc[i*INC_WIDTH +: INC_WIDTH]),
      .valid  (stat_valid[i]),
      .enable (channel_enable[i]),
      .clear  (acc_clear[i]),
      .acc    (acc[i])
    );
  end

  // Periodic flush timer.
  if (UPDATE_PERIOD == 0) begin : g_no_timer
    assign timer_hit = 1'b0;
  end else begin : g_timer
    localparam int unsigned TimerWidth = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
    logic [TimerWidth-1:0] timer_q;

    always_ff @(posedge clk) begin
      if (!rst_n || timer_q == '0) begin
        timer_q <= TimerWidth'(UPDATE_PERIOD - 1);
      end else begin
        timer_q <= timer_q - TimerWidth'(1);
      end
    end

    assign timer_hit = (timer_q == '0);
  end

  assign set_all = timer_hit | update;

  // Fold: the RAM word is masked until the channel's first WRITE after reset.
  always_comb begin
    base_val = zero_q[ch_q] ? '0 : mem_rd_q;
    add_res  = sat_add(SatMaxW'(base_val), SatMaxW'(acc[ch_q]), STAT_INC_WIDTH, SATURATE);
    sum      = add_res[STAT_INC_WIDTH-1:0];
    carry    = add_res[SatMaxW];
  end

  assign unused_add_bits = ^add_res[SatMaxW-1:STAT_INC_WIDTH];

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    zero_d    = zero_q;
    pending_d = pending_q;
    sat_d     = sat_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    tid_d     = tid_q;
    mem_we    = 1'b0;
    mem_wdata = sum;

    if (tvalid_q && m_axis_stat_tready) begin
      tvalid_d = 1'b0;
    end

    if (state_q == StRead) begin
      state_d = StWrite;
    end else begin
      state_d        = StRead;
      ch_d           = (ch_q == ChWidth'(COUNT - 1)) ? '0 : ch_q + ChWidth'(1);
      zero_d[ch_q]   = 1'b0;
      mem_we         = 1'b1;
      if (SATURATE && carry) begin
        sat_d[ch_q] = 1'b1;
      end
      if (pending_q[ch_q] && !tvalid_q) begin
        // Emit: the total moves into the output register. A zero total just retires pending.
        tdata_d         = sum;
        tid_d           = STAT_ID_WIDTH'(ch_q) + STAT_ID_WIDTH'(STAT_ID_BASE);
        tvalid_d        = (sum != '0);
        mem_wdata       = '0;
        pending_d[ch_q] = 1'b0;
        sat_d[ch_q]     = 1'b0;
      end else if (EARLY_FLUSH && sum[STAT_INC_WIDTH-1]) begin
        pending_d[ch_q] = 1'b1;
      end
    end

    // A flush request must not be lost to a same-cycle emit clear.
    if (set_all) begin
      pending_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StRead;
      ch_q      <= '0;
      zero_q    <= '1;
      pending_q <= '0;
      sat_q     <= '0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tid_q     <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      zero_q    <= zero_d;
      pending_q <= pending_d;
      sat_q     <= sat_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      tid_q     <= tid_d;
    end
  end

  // Distributed RAM: one write port and one registered read port, both addressed by ch.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ch_q] <= mem_wdata;
    end
    if (state_q == StRead) begin
      mem_rd_q <= mem[ch_q];
    end
  end

  assign m_axis_stat_tdata  = tdata_q;
  assign m_axis_stat_tid    = tid_q;
  assign m_axis_stat_tvalid = tvalid_q;
  assign sat_flag           = sat_q;

endmodule

// File: tb/tb_stats_collect_multi.sv
// Self-checking bench for stats_collect_multi.
// The reference model keeps per-channel input totals and per-channel emitted totals.
module tb_stats_collect_multi;

  localparam int unsigned Count  = 8;
  localparam int unsigned IdBase = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] stat_inc = '0;
  logic [7:0]  stat_valid = '0;
  logic [7:0]  channel_enable = '1;
  logic [15:0] tdata;
  logic [4:0]  tid;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        update = 1'b0;
  logic [7:0]  sat_flag;

  stats_collect_multi #(
    .COUNT          (8),
    .INC_WIDTH      (8),
    .STAT_INC_WIDTH (16),
    .STAT_ID_WIDTH  (5),
    .STAT_ID_BASE   (16),
    .UPDATE_PERIOD  (600),
    .SATURATE       (1'b1),
    .EARLY_FLUSH    (1'b1)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .stat_inc           (stat_inc),
    .stat_valid         (stat_valid),
    .channel_enable     (channel_enable),
    .m_axis_stat_tdata  (tdata),
    .m_axis_stat_tid    (tid),
    .m_axis_stat_tvalid (tvalid),
    .m_axis_stat_tready (tready),
    .update             (update),
    .sat_flag           (sat_flag)
  );

  always #5 clk = ~clk;

  int     n_vec = 0;
  int     n_err = 0;
  int     cyc = 0;
  int     rst_cyc = 0;

  longint exp_tot [Count];
  longint got_tot [Count];
  int     got_cnt [Count];
  int     rec_total;
  int     bad_tid;
  int     first_rec_cyc;
  longint first_rec_data;
  int     last_tid;
  longint last_tdata;

  logic        hold_prev = 1'b0;
  logic [15:0] prev_tdata;
  logic [4:0]  prev_tid;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int c = 0; c < Count; c++) begin
      exp_tot[c] = 0;
      got_tot[c] = 0;
      got_cnt[c] = 0;
    end
    rec_total      = 0;
    bad_tid        = 0;
    first_rec_cyc  = -1;
    first_rec_data = 0;
    last_tid       = -1;
    last_tdata     = -1;
  endtask

  // Record monitor: collects accepted records and checks that a stalled record holds still.
  always @(negedge clk) begin
    if (rst_n && tvalid) begin
      if (hold_prev) begin
        check_eq("hold_tdata", longint'(tdata), longint'(prev_tdata));
        check_eq("hold_tid", longint'(tid), longint'(prev_tid));
      end
      if (tready) begin
        int c;
        c = int'(tid) - int'(IdBase);
        check_eq("rec_nonzero", longint'(tdata != 16'd0), 1);
        if (c >= 0 && c < int'(Count)) begin
          got_tot[c] += longint'(tdata);
          got_cnt[c]++;
        end else begin
          bad_tid++;
        end
        if (first_rec_cyc < 0) begin
          first_rec_cyc  = cyc - rst_cyc;
          first_rec_data = longint'(tdata);
        end
        last_tid   = int'(tid);
        last_tdata = longint'(tdata);
        rec_total++;
        hold_prev  = 1'b0;
      end else begin
        hold_prev  = 1'b1;
        prev_tdata = tdata;
        prev_tid   = tid;
      end
    end else begin
      hold_prev = 1'b0;
    end
  end

  // One clock of stimulus; the model counts increments the DUT is allowed to see.
  task automatic drive(input logic [63:0] inc, input logic [7:0] vld, input logic [7:0] en,
                       input logic upd);
    stat_inc       = inc;
    stat_valid     = vld;
    channel_enable = en;
    update         = upd;
    @(posedge clk);
    for (int c = 0; c < Count; c++) begin
      if (vld[c] && en[c]) exp_tot[c] += longint'(inc[c*8 +: 8]);
    end
    #1;
    update = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0, '1, 1'b0);
  endtask

  task automatic one_ch(input int ch, input logic [7:0] val, input int n);
    logic [63:0] v;
    logic [7:0]  m;
    v = '0;
    m = '0;
    v[ch*8 +: 8] = val;
    m[ch] = 1'b1;
    for (int i = 0; i < n; i++) drive(v, m, '1, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    clear_model();
    rst_cyc = cyc;
  endtask

  task automatic drain();
    tready = 1'b1;
    drive('0, '0, '1, 1'b1);
    idle(40);
  endtask

  task automatic check_totals(input string tag);
    for (int c = 0; c < Count; c++) begin
      check_eq($sformatf("%s_ch%0d", tag, c), got_tot[c], exp_tot[c]);
    end
    check_eq({tag, "_badtid"}, bad_tid, 0);
  endtask

  task automatic rand_cycle(input int max_inc, input logic rand_en, input logic rand_upd);
    logic [63:0] v;
    logic [7:0]  m;
    logic [7:0]  e;
    for (int c = 0; c < Count; c++) v[c*8 +: 8] = 8'($urandom_range(0, max_inc));
    m = 8'($urandom);
    e = rand_en ? (8'($urandom) | 8'($urandom)) : 8'hff;
    drive(v, m, e, rand_upd && ($urandom_range(0, 39) == 0));
  endtask

  initial begin
    clear_model();
    tready = 1'b1;
    do_reset();

    // Reset state.
    check_eq("rst_tvalid", longint'(tvalid), 0);
    check_eq("rst_tdata", longint'(tdata), 0);
    check_eq("rst_tid", longint'(tid), 0);
    check_eq("rst_sat", longint'(sat_flag), 0);

    // Channel 2: 5 x 10, then one update gives exactly one record of 50.
    one_ch(2, 8'd5, 10);
    idle(5);
    drain();
    check_eq("t1_records", rec_total, 1);
    check_eq("t1_cnt2", got_cnt[2], 1);
    check_eq("t1_tid", last_tid, 18);
    check_eq("t1_tdata", last_tdata, 50);

    // ID base offset on the last channel.
    do_reset();
    one_ch(7, 8'd1, 3);
    drain();
    check_eq("t2_records", rec_total, 1);
    check_eq("t2_tid", last_tid, 23);
    check_eq("t2_tdata", last_tdata, 3);

    // Disabled channel ignores its valid; an enabled neighbour still counts.
    do_reset();
    for (int i = 0; i < 20; i++) drive({24'd0, 8'd2, 8'd9, 24'd0}, 8'h18, 8'hf7, 1'b0);
    drain();
    check_eq("en_cnt3", got_cnt[3], 0);
    check_eq("en_tot4", got_tot[4], 40);
    check_totals("en");

    // Early flush: a record appears without any update once the total crosses 32768.
    do_reset();
    one_ch(1, 8'd200, 250);
    check_eq("ef_seen", longint'(first_rec_cyc >= 0 && first_rec_cyc < 260), 1);
    check_eq("ef_msb", longint'(first_rec_data >= 32768), 1);
    drain();
    check_totals("ef");

    // Periodic timer flush after 600 cycles.
    do_reset();
    one_ch(5, 8'd7, 4);
    for (int i = 0; i < 700 && rec_total == 0; i++) idle(1);
    check_eq("tm_seen", rec_total, 1);
    check_eq("tm_when", longint'(first_rec_cyc >= 598 && first_rec_cyc <= 620), 1);
    check_eq("tm_tid", last_tid, 21);
    check_eq("tm_tdata", last_tdata, 28);

    // Saturation while the output is blocked by a held record.
    do_reset();
    tready = 1'b0;
    one_ch(1, 8'd1, 1);
    drive('0, '0, '1, 1'b1);
    idle(20);
    one_ch(0, 8'd255, 300);
    idle(20);
    check_eq("sat_set", longint'(sat_flag[0]), 1);
    check_eq("sat_held_tvalid", longint'(tvalid), 1);
    check_eq("sat_held_tid", longint'(tid), 17);
    tready = 1'b1;
    idle(40);
    check_eq("sat_cnt0", got_cnt[0], 1);
    check_eq("sat_tot0", got_tot[0], (exp_tot[0] > 65535) ? 65535 : exp_tot[0]);
    check_eq("sat_tot1", got_tot[1], 1);
    check_eq("sat_clear", longint'(sat_flag), 0);

    // Long backpressure with every channel active.
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < 50; i++) rand_cycle(15, 1'b0, 1'b0);
    drive('0, '0, '1, 1'b1);
    for (int i = 0; i < 450; i++) rand_cycle(15, 1'b0, 1'b0);
    check_eq("bp_none", rec_total, 0);
    check_eq("bp_tvalid", longint'(tvalid), 1);
    drain();
    check_totals("bp");

    // Random traffic, enables, backpressure and updates.
    do_reset();
    for (int i = 0; i < 700; i++) begin
      tready = 1'($urandom);
      rand_cycle(63, 1'b1, 1'b1);
    end
    drain();
    check_totals("rnd");

    // Reset while a record is held: it is dropped and nothing stale follows.
    do_reset();
    tready = 1'b0;
    one_ch(6, 8'd3, 1);
    drive('0, '0, '1, 1'b1);
    idle(20);
    check_eq("mr_held", longint'(tvalid), 1);
    rst_n = 1'b0;
    idle(1);
    check_eq("mr_drop", longint'(tvalid), 0);
    rst_n = 1'b1;
    clear_model();
    rst_cyc = cyc;
    tready = 1'b1;
    idle(100);
    check_eq("mr_no_stale", rec_total, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stats_collect_multi.md
# stats_collect_multi

Parametrised statistics collector: accumulates per-channel event increments in small local accumulators, folds them into a per-channel distributed-RAM total, and emits non-zero totals as AXI-stream (tdata, tid) increment records to the downstream statistics counter block. It adds three features to the single-mode collector: saturating totals, early flush near overflow, and per-channel enables with an ID base offset. This lets several instances share one counter address space.

## Interface
- COUNT, 8: channel count, ≥2
- INC_WIDTH, 8: per-channel increment width
- STAT_INC_WIDTH, 16: emitted increment width
- STAT_ID_WIDTH, $clog2(COUNT)+1: tid width; must hold STAT_ID_BASE+COUNT-1
- STAT_ID_BASE, 0: added to channel index to form tid
- UPDATE_PERIOD, 1024: cycles between automatic flush requests; 0 disables the timer
- SATURATE, 1: 1 = totals clamp at all-ones; 0 = totals wrap
- EARLY_FLUSH, 1: 1 = a total with MSB set forces that channel pending
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- stat_inc  in  INC_WIDTH*COUNT  per-channel increment, channel n at [n*INC_WIDTH +: INC_WIDTH]
- stat_valid  in  COUNT  per-channel increment qualifier
- channel_enable  in  COUNT  a 0 bit makes the channel ignore stat_valid
- m_axis_stat_tdata  out  STAT_INC_WIDTH  increment value
- m_axis_stat_tid  out  STAT_ID_WIDTH  counter ID
- m_axis_stat_tvalid  out  1  record valid
- m_axis_stat_tready  in  1  downstream accept
- update  in  1  single-cycle pulse; marks all channels pending
- sat_flag  out  COUNT  sticky per channel; set when its total saturated; cleared when that channel emits

## Operation
- Accumulator per channel, ACC_WIDTH = INC_WIDTH+$clog2(COUNT)+1.
  - Adds stat_inc when stat_valid && channel_enable.
  - On clear, loads the same-cycle increment (or 0), so no increment is lost.
  - Width covers 2*COUNT cycles of maximum increments, so it cannot overflow between visits.
- Scan FSM, states READ and WRITE, alternating every cycle. Pointer ch steps 0..COUNT-1 and wraps to 0 after each WRITE.
- READ: registered read of mem[ch].
- WRITE:
  - raw = (zero[ch] ? 0 : mem_rd) + acc[ch], computed at STAT_INC_WIDTH+1 bits.
  - With SATURATE=1: if the carry is set, sum = all-ones and sat_flag[ch] is set.
  - With SATURATE=0: sum is raw truncated.
  - acc[ch] is cleared and zero[ch] is cleared.
- Emit path: if pending[ch] && !tvalid_reg:
  - tdata = sum, tid = ch+STAT_ID_BASE.
  - tvalid = (sum != 0).
  - mem[ch] <= 0, pending[ch] cleared, sat_flag[ch] cleared.
- Otherwise mem[ch] <= sum. If EARLY_FLUSH and sum[MSB] is set, pending[ch] is set for the next visit.
- A pending channel that finds the output busy stays pending and is retried on its next visit.
- Output register: tvalid holds until tready; tdata and tid are stable while tvalid is high.
- Timer:
  - Counts down from UPDATE_PERIOD-1.
  - At 0 it sets all pending and reloads.
  - The update pulse also sets all pending.
  - Set-all takes priority over the same-cycle WRITE clear.
- Disabled channels still scan and flush their residual totals.

## Timing
- Reset (rst_n=0 at an edge):
  - tvalid=0, tdata=0, tid=0, sat_flag=0.
  - FSM=READ, ch=0, pending=0, zero=all-ones, accumulators=0.
  - Timer reloaded to UPDATE_PERIOD-1.
  - The mem contents are don't-care, because zero masks them.
- Reset mid-record drops the pending tvalid; no partial state survives.
- Channel visit period is exactly 2*COUNT cycles; the scan never stalls on tready.
- Latency from update to the first record: ≤2*COUNT+1 cycles. Worst case for all channels to emit with tready=1: 2*COUNT cycles after update plus 1.
- Throughput: at most one record per channel visit, i.e. one per 2 cycles.
- An increment arriving in a channel's WRITE cycle is counted in the next visit.

## Structure
- Shared package `stats_pkg`:
  - FSM state encoding
  - ACC_WIDTH derivation function
  - saturating-add function, shared with future stats blocks
- Sub-module `stats_acc`: one channel accumulator with inc/valid/enable/clear ports, instantiated COUNT times in a generate loop.
- The mem array is inferred distributed RAM: one read port and one write port, addressed by ch.

## Test plan
- Channel 2 gets stat_inc=5 for 10 cycles, then update pulses, tready=1 → exactly one record tid=2, tdata=50; no other records.
- STAT_ID_BASE=16, channel 7 gets +1 ×3, then update → record tid=23, tdata=3.
- SATURATE=1, STAT_INC_WIDTH=8, channel 0 gets 255/cycle for 100 cycles, then update → tdata=255 and sat_flag[0] set; sat_flag[0] clears after the record.
- EARLY_FLUSH=1, UPDATE_PERIOD=0, channel 1 gets +200/cycle (STAT_INC_WIDTH=16) → a record appears without update once the total reaches ≥32768; the sum of all records equals the total input.
- tready held 0 for 500 cycles, all channels active, update pulsed → one record held stable; after release every channel's records sum to its exact input total.
- channel_enable[3]=0 while stat_valid[3]=1 → no record for tid 3. rst_n asserted mid-record → tvalid=0 on the next cycle and no stale record afterward.
